// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for a 5-stage RISC-V pipeline.
// Resolves RAW hazards by forwarding from M/W or, when forwarding is
// disabled, by stalling in D. Also handles the load-use stall, the
// taken-branch flush and a multi-cycle EX stall sequencer, and keeps
// saturating perf counters of stall and flush cycles.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   RS1_D, RS2_D              source registers of the instruction in D
//   RS1_E, RS2_E              source registers of the instruction in E
//   RD_E, RD_M, RD_W          destination registers in E/M/W
//   RegWriteE/M/W             destination write valid per stage
//   ResultSrcE                instruction in E is a load
//   PCSrcE                    taken branch/jump resolved in E
//   MultiCycleE               instruction in E is a multi-cycle op
//   CntClr                    synchronous clear of the perf counters
//   ForwardAE, ForwardBE      00 regfile, 10 from M, 01 from W
//   StallF, StallD, StallE    hold PC / IF-ID / ID-EX registers
//   FlushD, FlushE            zero IF-ID / ID-EX registers
//   BubbleM                   bubble into EX-MEM while EX is busy
//   McDoneE                   multi-cycle result valid this cycle
//   StallCnt, FlushCnt        saturating perf counters
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RS1_D,
  input  logic [REG_AW-1:0] RS2_D,
  input  logic [REG_AW-1:0] RS1_E,
  input  logic [REG_AW-1:0] RS2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MultiCycleE,
  input  logic              CntClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BubbleM,
  output logic              McDoneE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  // Down-counter only has to hold MC_LAT-2.
  localparam int unsigned MC_CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [MC_CW-1:0] MC_LOAD = MC_CW'(MC_LAT - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  mc_state_t        state;
  logic [MC_CW-1:0] cnt;
  logic             mc_stall;
  logic             lw_stall;
  logic             raw_stall;
  logic             hz_stall;

  // Multi-cycle EX sequencer; McDoneE is registered and high only in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      McDoneE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          McDoneE <= 1'b0;
          if (MultiCycleE) begin
            if (MC_LAT > 2) begin
              state <= BUSY;
              cnt   <= MC_LOAD;
            end else begin
              state   <= DONE;
              McDoneE <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == MC_CW'(1)) begin
            state   <= DONE;
            McDoneE <= 1'b1;
          end else begin
            cnt <= cnt - MC_CW'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          McDoneE <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          McDoneE <= 1'b0;
        end
      endcase
    end
  end

  // EX is held from the cycle the op is seen in IDLE until it reaches DONE.
  assign mc_stall = ((state == IDLE) && MultiCycleE) || (state == BUSY);

  // Load-use and (forwarding-disabled) RAW hazard detection on the D sources.
  always_comb begin
    lw_stall  = ResultSrcE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
    raw_stall = 1'b0;
    if (FWD_EN == 0) begin
      raw_stall = ((RS1_D != '0) && ((RegWriteE && (RD_E == RS1_D)) ||
                                     (RegWriteM && (RD_M == RS1_D)))) ||
                  ((RS2_D != '0) && ((RegWriteE && (RD_E == RS2_D)) ||
                                     (RegWriteM && (RD_M == RS2_D))));
    end
    hz_stall = lw_stall || raw_stall;
  end

  // Hazard outputs; priority is multi-cycle stall, then branch, then hazard stall.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    BubbleM   = 1'b0;
    if (rst) begin
      if (FWD_EN != 0) begin
        if (RegWriteM && (RD_M != '0) && (RD_M == RS1_E))      ForwardAE = 2'b10;
        else if (RegWriteW && (RD_W != '0) && (RD_W == RS1_E)) ForwardAE = 2'b01;
        if (RegWriteM && (RD_M != '0) && (RD_M == RS2_E))      ForwardBE = 2'b10;
        else if (RegWriteW && (RD_W != '0) && (RD_W == RS2_E)) ForwardBE = 2'b01;
      end
      if (mc_stall) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        BubbleM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (hz_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Saturating perf counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Instance a: defaults (forwarding,
// MC_LAT=4, 16-bit counters). Instance b: FWD_EN=0, MC_LAT=2, 4-bit counters.
// Inputs change on the falling edge and outputs are checked 1ns later.
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE, CntClr;

  logic [1:0]  a_fa, a_fb, b_fa, b_fb;
  logic        a_sf, a_sd, a_se, a_fd, a_fe, a_bm, a_md;
  logic        b_sf, b_sd, b_se, b_fd, b_fe, b_bm, b_md;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit u_a (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .CntClr(CntClr),
    .ForwardAE(a_fa), .ForwardBE(a_fb),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
    .FlushD(a_fd), .FlushE(a_fe), .BubbleM(a_bm), .McDoneE(a_md),
    .StallCnt(a_sc), .FlushCnt(a_fc)
  );

  hazard_ctrl_unit #(.REG_AW(5), .MC_LAT(2), .FWD_EN(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .CntClr(CntClr),
    .ForwardAE(b_fa), .ForwardBE(b_fb),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
    .FlushD(b_fd), .FlushE(b_fe), .BubbleM(b_bm), .McDoneE(b_md),
    .StallCnt(b_sc), .FlushCnt(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    RS1_D = '0; RS2_D = '0; RS1_E = '0; RS2_E = '0;
    RD_E = '0; RD_M = '0; RD_W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    ResultSrcE = 0; PCSrcE = 0; MultiCycleE = 0; CntClr = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset: active hazards on the inputs must not reach the outputs.
    rst = 1'b0;
    clr_in();
    PCSrcE = 1; MultiCycleE = 1; RS1_E = 5; RD_M = 5; RegWriteM = 1;
    #1;
    chk("rst_fwdA", a_fa, 2'b00);
    chk("rst_flushD", a_fd, 0);
    chk("rst_stallE", a_se, 0);
    chk("rst_stallcnt", a_sc, 0);
    chk("rst_mcdone", a_md, 0);
    step(); step();
    rst = 1'b1; clr_in();

    // Forwarding: M beats W, x0 never forwards.
    step(); RD_M = 5; RD_W = 5; RS1_E = 5; RegWriteM = 1; RegWriteW = 1; #1;
    chk("fwdA_M", a_fa, 2'b10);
    chk("fwdA_nofwd_b", b_fa, 2'b00);
    step(); RD_M = 0; #1;
    chk("fwdA_W", a_fa, 2'b01);
    step(); RS1_E = 0; RS2_E = 5; #1;
    chk("fwdA_x0", a_fa, 2'b00);
    chk("fwdB_W", a_fb, 2'b01);
    step(); RD_M = 5; #1;
    chk("fwdB_M", a_fb, 2'b10);

    // Load-use stall, then the same with a taken branch.
    step(); clr_in(); ResultSrcE = 1; RD_E = 7; RegWriteE = 1; RS2_D = 7; #1;
    chk("lw_stallF", a_sf, 1);
    chk("lw_stallD", a_sd, 1);
    chk("lw_flushE", a_fe, 1);
    chk("lw_flushD", a_fd, 0);
    chk("lw_stallE", a_se, 0);
    step(); PCSrcE = 1; #1;
    chk("br_flushD", a_fd, 1);
    chk("br_flushE", a_fe, 1);
    chk("br_stallF", a_sf, 0);
    chk("br_stallD", a_sd, 0);

    // Multi-cycle ops with MultiCycleE held (a: 3 stall + DONE, b: 1 stall + DONE).
    step(); clr_in(); MultiCycleE = 1; #1;
    chk("mc0_a_stallE", a_se, 1);
    chk("mc0_a_bubble", a_bm, 1);
    chk("mc0_b_stallE", b_se, 1);
    step(); PCSrcE = 1; ResultSrcE = 1; RD_E = 7; RS1_D = 7; #1;
    chk("mc1_a_stallE", a_se, 1);
    chk("mc1_a_flushD", a_fd, 0);
    chk("mc1_a_flushE", a_fe, 0);
    chk("mc1_a_stallF", a_sf, 1);
    chk("mc1_a_bubble", a_bm, 1);
    chk("mc1_b_done", b_md, 1);
    chk("mc1_b_stallE", b_se, 0);
    step(); PCSrcE = 0; ResultSrcE = 0; RD_E = 0; RS1_D = 0; #1;
    chk("mc2_a_stallE", a_se, 1);
    chk("mc2_a_done", a_md, 0);
    chk("mc2_b_stallE", b_se, 1);
    chk("mc2_b_done", b_md, 0);
    step(); #1;
    chk("mc3_a_done", a_md, 1);
    chk("mc3_a_stallE", a_se, 0);
    chk("mc3_a_stallF", a_sf, 0);
    step(); #1;
    chk("mc4_a_retrig", a_se, 1);
    chk("mc4_a_done", a_md, 0);
    step(); MultiCycleE = 0; #1;
    chk("mc5_a_stallE", a_se, 1);
    chk("mc5_b_done", b_md, 1);
    step(); #1;
    chk("mc6_a_stallE", a_se, 1);
    chk("mc6_b_idle", b_se, 0);
    step(); #1;
    chk("mc7_a_done", a_md, 1);
    step(); #1;
    chk("mc8_a_stallE", a_se, 0);
    chk("mc8_a_done", a_md, 0);

    // RAW resolution by stalling when forwarding is disabled.
    step(); clr_in(); RD_M = 3; RegWriteM = 1; RS1_D = 3; RS1_E = 3; #1;
    chk("raw_b_stallD", b_sd, 1);
    chk("raw_b_flushE", b_fe, 1);
    chk("raw_b_fwdA", b_fa, 2'b00);
    chk("raw_a_stallD", a_sd, 0);
    chk("raw_a_fwdA", a_fa, 2'b10);
    step(); clr_in(); RD_E = 4; RegWriteE = 1; RS2_D = 4; #1;
    chk("rawE_b_stallD", b_sd, 1);
    chk("rawE_a_stallD", a_sd, 0);
    step(); clr_in(); RD_W = 6; RegWriteW = 1; RS1_D = 6; #1;
    chk("rawW_b_stallD", b_sd, 0);

    // Counters: clear, 20 stall cycles, 3 flush cycles, clear beats increment.
    step(); clr_in(); CntClr = 1;
    step(); CntClr = 0; #1;
    chk("clr_a_sc", a_sc, 0);
    chk("clr_b_fc", b_fc, 0);
    ResultSrcE = 1; RD_E = 7; RS1_D = 7;
    repeat (20) step();
    #1;
    chk("cnt_a_sc20", a_sc, 20);
    chk("cnt_b_sat", b_sc, 15);
    chk("cnt_a_fc0", a_fc, 0);
    ResultSrcE = 0; PCSrcE = 1;
    repeat (3) step();
    #1;
    chk("cnt_a_fc3", a_fc, 3);
    chk("cnt_b_fc3", b_fc, 3);
    chk("cnt_a_sc_hold", a_sc, 20);
    CntClr = 1;
    step(); #1;
    chk("clrpri_a_sc", a_sc, 0);
    chk("clrpri_a_fc", a_fc, 0);
    chk("clrpri_b_sc", b_sc, 0);
    CntClr = 0;
    step(); #1;
    chk("post_a_fc1", a_fc, 1);
    chk("post_a_sc0", a_sc, 0);

    // Reset in BUSY returns to IDLE with no McDoneE.
    step(); clr_in(); MultiCycleE = 1;
    step(); rst = 1'b0; #1;
    chk("rbusy_a_stallE", a_se, 0);
    chk("rbusy_a_done", a_md, 0);
    chk("rbusy_a_fc", a_fc, 0);
    step(); rst = 1'b1; MultiCycleE = 0; #1;
    chk("rrel_a_stallE", a_se, 0);
    chk("rrel_a_done", a_md, 0);
    step(); #1;
    chk("rrel2_a_done", a_md, 0);
    chk("rrel2_a_stallE", a_se, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
